// File: rtl/loop_addr_gen_if.sv
// loop_addr_gen_if: start/job, counter-side and address-stream signals of the loop address generator
interface loop_addr_gen_if #(
    parameter int NDEPTH   = 3,
    parameter int IDXMAXDW = 11,
    parameter int STRIDEDW = 16,
    parameter int ADDRDW   = 16
);
    logic                               start;
    logic [ADDRDW-1:0]                  base;
    logic [NDEPTH-1:0][STRIDEDW-1:0]    stride;
    logic [NDEPTH-1:0][IDXMAXDW-1:0]    loop_idx;
    logic [NDEPTH-1:0]                  loop_end;
    logic [2:0]                         ctl;
    logic [ADDRDW-1:0]                  addr;
    logic                               addr_last;
    logic                               addr_val;
    logic                               addr_rdy;
    logic                               busy;
    logic                               done;
    modport master (
        input  start, base, stride, loop_idx, loop_end, addr_rdy,
        output ctl, addr, addr_last, addr_val, busy, done
    );
    modport slave (
        output start, base, stride, loop_idx, loop_end, addr_rdy,
        input  ctl, addr, addr_last, addr_val, busy, done
    );
endinterface

// File: rtl/loop_addr_gen.sv
// loop_addr_gen: drives a nested LoopCounter and streams base + sum((idx_i-1)*stride_i) per loop point
module loop_addr_gen #(
    parameter int NDEPTH   = 3,
    parameter int IDXMAXDW = 11,
    parameter int STRIDEDW = 16,
    parameter int ADDRDW   = 16
) (
    input logic             i_clk,
    input logic             i_rst,
    loop_addr_gen_if.master bus
);
    localparam int PW = IDXMAXDW + STRIDEDW;
    typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, DONE} state_t;
    state_t                          state_q, state_d;
    logic [ADDRDW-1:0]               base_q, base_d, addr_q, addr_d, offset;
    logic [NDEPTH-1:0][STRIDEDW-1:0] stride_q, stride_d;
    logic                            val_q, val_d, last_q, last_d, done_q, done_d;
    logic                            load, all_end;
    logic [PW-1:0]                   prod;
    logic [2:0]                      ctl;
    assign all_end = &bus.loop_end;
    assign load    = (state_q == RUN) && (!val_q || bus.addr_rdy);
    // an index of 0 saturates to a zero term instead of underflowing
    always_comb begin
        offset = '0;
        prod   = '0;
        for (int i = 0; i < NDEPTH; i++) begin
            prod   = (bus.loop_idx[i] == '0) ? '0 :
                     PW'(bus.loop_idx[i] - IDXMAXDW'(1)) * PW'(stride_q[i]);
            offset = offset + ADDRDW'(prod);
        end
    end
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        stride_d = stride_q;
        addr_d   = addr_q;
        val_d    = val_q;
        last_d   = last_q;
        done_d   = (state_q == DONE);
        ctl      = 3'b000;
        case (state_q)
            IDLE: if (bus.start) begin
                base_d   = bus.base;
                stride_d = bus.stride;
                state_d  = INIT;
            end
            INIT: begin
                ctl     = 3'b101;
                state_d = RUN;
            end
            RUN: if (load) begin
                addr_d  = base_q + offset;
                val_d   = 1'b1;
                last_d  = all_end;
                ctl     = all_end ? 3'b000 : 3'b110;
                state_d = all_end ? DRAIN : RUN;
            end
            DRAIN: if (bus.addr_rdy && val_q) begin
                val_d   = 1'b0;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            base_q   <= '0;
            stride_q <= '0;
            addr_q   <= '0;
            val_q    <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            stride_q <= stride_d;
            addr_q   <= addr_d;
            val_q    <= val_d;
            last_q   <= last_d;
            done_q   <= done_d;
        end
    end
    assign bus.ctl       = ctl;
    assign bus.addr      = addr_q;
    assign bus.addr_val  = val_q;
    assign bus.addr_last = last_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
endmodule

// File: tb/tb_loop_addr_gen.sv
// tb_loop_addr_gen: scoreboard bench with a behavioural LoopCounter (STARTPOINT = 1)
module tb_loop_addr_gen;
    localparam int ND = 3, IW = 11, SW = 16, AW = 16;
    localparam logic [ND*IW-1:0] ONES = {ND{IW'(1)}};
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    loop_addr_gen_if #(.NDEPTH(ND), .IDXMAXDW(IW), .STRIDEDW(SW), .ADDRDW(AW)) bus ();
    loop_addr_gen #(.NDEPTH(ND), .IDXMAXDW(IW), .STRIDEDW(SW), .ADDRDW(AW)) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus)
    );
    int tests = 0, fails = 0, cyc = 0;
    int size [ND];
    int rdy_mode = 0, first_cyc = -1, acc_cyc = -1, done_cyc = -1, acc_cnt = 0;
    logic [AW:0] sb[$];
    logic [AW:0] held;
    bit stall_prev = 0;
    logic [ND-1:0][IW-1:0] idx = ONES, nxt;
    logic c;
    always @(posedge clk) cyc <= cyc + 1;
    // behavioural counter: loopEnd when idx reaches size, size 0 ends permanently at idx 1
    assign bus.loop_idx = idx;
    always_comb begin
        bus.loop_end = '0;
        for (int i = 0; i < ND; i++) bus.loop_end[i] = (size[i] == 0) || (int'(idx[i]) >= size[i]);
    end
    always_comb begin
        c   = 1'b1;
        nxt = idx;
        for (int i = 0; i < ND; i++)
            if (c) begin
                if (bus.loop_end[i]) nxt[i] = IW'(1);
                else begin
                    nxt[i] = idx[i] + IW'(1);
                    c      = 1'b0;
                end
            end
    end
    always @(posedge clk or posedge rst) begin
        if (rst) idx <= ONES;
        else if (bus.ctl[2] && bus.ctl[0]) idx <= ONES;
        else if (bus.ctl[2] && bus.ctl[1]) idx <= nxt;
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask
    task automatic push(input logic [AW-1:0] a, input logic l);
        sb.push_back({l, a});
    endtask
    initial begin
        bus.addr_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1 bus.addr_rdy = (rdy_mode == 0) || (cyc % 3 == 0);
        end
    end
    // monitor: pops the scoreboard on every accepted beat, checks stability while stalled
    initial forever begin
        @(negedge clk);
        if (rst) stall_prev = 0;
        else begin
            if (bus.done) done_cyc = cyc;
            if (bus.addr_val) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (stall_prev) chk("stable", {15'd0, bus.addr_last, bus.addr}, {15'd0, held});
                if (bus.addr_rdy) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_addr: got 0x%0h expected none", bus.addr);
                    end else chk("addr", {15'd0, bus.addr_last, bus.addr}, {15'd0, sb.pop_front()});
                    acc_cnt++;
                    acc_cyc    = cyc;
                    stall_prev = 0;
                end else begin
                    chk("stall_inc", {31'd0, bus.ctl[1]}, 32'd0);
                    stall_prev = 1;
                    held       = {bus.addr_last, bus.addr};
                end
            end else stall_prev = 0;
        end
    end
    task automatic run_job(input logic [AW-1:0] b, input logic [ND-1:0][SW-1:0] st,
                           input int s0, input int s1, input int s2, input int mode, input bit poke);
        int sc, n;
        size[0] = s0; size[1] = s1; size[2] = s2;
        rdy_mode = mode; first_cyc = -1; done_cyc = -1;
        @(posedge clk);
        #1 bus.base = b; bus.stride = st; bus.start = 1'b1; sc = cyc;
        @(posedge clk);
        #1 bus.start = 1'b0; bus.base = '0; bus.stride = '0;
        @(negedge clk);
        chk("busy", {31'd0, bus.busy}, 32'd1);
        if (poke) begin
            repeat (2) @(posedge clk);
            #1 bus.start = 1'b1; bus.base = 16'hdead;
            @(posedge clk);
            #1 bus.start = 1'b0; bus.base = '0;
        end
        n = 0;
        while (done_cyc < 0 && n < 200) begin
            @(negedge clk);
            #1 n++;
        end
        chk("done_seen", {31'd0, done_cyc >= 0}, 32'd1);
        chk("first_val_lat", first_cyc - sc, 32'd3);
        chk("done_lat", done_cyc - acc_cyc, 32'd2);
        chk("sb_empty", sb.size(), 32'd0);
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);
    endtask
    initial begin
        int n;
        bus.start = 1'b0; bus.base = '0; bus.stride = '0;
        for (int i = 0; i < ND; i++) size[i] = 1;
        #1;
        chk("rst_val", {31'd0, bus.addr_val}, 32'd0);
        chk("rst_addr", {16'd0, bus.addr}, 32'd0);
        chk("rst_last", {31'd0, bus.addr_last}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_ctl", {29'd0, bus.ctl}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        push(16'h0100, 0); push(16'h0101, 0); push(16'h0104, 0); push(16'h0105, 1);
        run_job(16'h0100, {16'd32, 16'd4, 16'd1}, 2, 2, 1, 0, 0);
        push(16'h0100, 0); push(16'h0101, 0); push(16'h0104, 0); push(16'h0105, 1);
        run_job(16'h0100, {16'd32, 16'd4, 16'd1}, 2, 2, 1, 1, 0);
        push(16'd0, 0); push(16'd2, 0); push(16'd4, 0); push(16'd10, 0); push(16'd12, 0); push(16'd14, 1);
        run_job(16'h0000, {16'd10, 16'd100, 16'd2}, 3, 0, 2, 0, 0);
        push(16'hfff0, 0); push(16'h0000, 0); push(16'h0010, 1);
        run_job(16'hfff0, {16'd9, 16'd7, 16'h0010}, 3, 1, 1, 0, 0);
        push(16'h0100, 0); push(16'h0101, 0); push(16'h0104, 0); push(16'h0105, 1);
        run_job(16'h0100, {16'd32, 16'd4, 16'd1}, 2, 2, 1, 0, 1);
        push(16'h0042, 1);
        run_job(16'h0042, {16'd5, 16'd6, 16'd7}, 1, 1, 1, 0, 0);
        // abort mid-job with reset after the second address is accepted
        push(16'h0100, 0); push(16'h0101, 0); push(16'h0104, 0); push(16'h0105, 1);
        size[0] = 2; size[1] = 2; size[2] = 1; rdy_mode = 0; acc_cnt = 0;
        @(posedge clk);
        #1 bus.base = 16'h0100; bus.stride = {16'd32, 16'd4, 16'd1}; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        n = 0;
        while (acc_cnt < 2 && n < 50) begin
            @(negedge clk);
            #1 n++;
        end
        chk("rst_wait", acc_cnt, 32'd2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_val", {31'd0, bus.addr_val}, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_autostart", {30'd0, bus.busy, bus.addr_val}, 32'd0);
        push(16'h0100, 0); push(16'h0101, 0); push(16'h0104, 0); push(16'h0105, 1);
        run_job(16'h0100, {16'd32, 16'd4, 16'd1}, 2, 2, 1, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
